// File: rtl/mpi_bb_mc_pkg.sv
// Shared register map, STATUS bit layout and FSM state types for the
// multi-channel Blackbone message-passing endpoint.
package mpi_bb_mc_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_SEND   = 2'd3;

  localparam int ST_RXAVAIL    = 0;
  localparam int ST_TXBUSY     = 1;
  localparam int ST_TXERR      = 2;
  localparam int ST_RXDROP     = 3;
  localparam int ST_TXDONE     = 4;
  localparam int ST_RXREM_LSB  = 8;
  localparam int ST_TXFILL_LSB = 16;

  typedef enum logic {
    TX_FILL,
    TX_SEND
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_EMPTY,
    RX_RECV,
    RX_DROP,
    RX_FULL
  } rx_state_t;

endpackage

// File: rtl/mpi_bb_mc_channel.sv
// One endpoint channel: egress/ingress packet buffers, their FSMs,
// CTRL and sticky STATUS bits, and this channel's interrupt term.
module mpi_bb_mc_channel
  import mpi_bb_mc_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr,
  input  logic                      i_rd,
  input  logic [1:0]                i_reg,
  input  logic [31:0]               i_wdata,
  output logic [31:0]               o_rdata,
  output logic [NOC_FLIT_WIDTH-1:0] o_out_flit,
  output logic                      o_out_last,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  input  logic [NOC_FLIT_WIDTH-1:0] i_in_flit,
  input  logic                      i_in_last,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  output logic                      o_irq
);

  localparam int         AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [7:0] SIZE_C = 8'(SIZE);

  tx_state_t r_tx_state, w_tx_next;
  rx_state_t r_rx_state, w_rx_next;

  logic [NOC_FLIT_WIDTH-1:0] r_txbuf [SIZE];
  logic [NOC_FLIT_WIDTH-1:0] r_rxbuf [SIZE];
  logic [7:0] r_txfill, r_txrd, r_wcnt, r_rxrem, r_rdptr;
  logic [1:0] r_ctrl;
  logic       r_txerr, r_rxdrop, r_txdone;

  logic w_data_wr, w_stat_wr, w_ctrl_wr, w_send_wr, w_data_rd;
  logic w_tx_push, w_tx_err, w_tx_hs, w_tx_last;
  logic w_in_hs, w_rx_overflow, w_rx_store, w_rx_drop_done, w_rx_pop;
  logic w_unused_wdata;

  assign w_unused_wdata = ^i_wdata;

  always_comb begin
    w_data_wr      = i_wr && (i_reg == REG_DATA);
    w_stat_wr      = i_wr && (i_reg == REG_STATUS);
    w_ctrl_wr      = i_wr && (i_reg == REG_CTRL);
    w_send_wr      = i_wr && (i_reg == REG_SEND);
    w_data_rd      = i_rd && (i_reg == REG_DATA);
    w_tx_push      = w_data_wr && (r_tx_state == TX_FILL) && (r_txfill < SIZE_C);
    w_tx_err       = w_data_wr && !w_tx_push;
    w_tx_last      = (r_txrd == r_txfill - 8'd1);
    w_tx_hs        = (r_tx_state == TX_SEND) && i_out_ready;
    w_in_hs        = i_in_valid && o_in_ready;
    // A flit arriving with the buffer already full turns the packet into a drop.
    w_rx_overflow  = ((r_rx_state == RX_EMPTY) || (r_rx_state == RX_RECV)) && (r_wcnt == SIZE_C);
    w_rx_store     = w_in_hs && ((r_rx_state == RX_EMPTY) || (r_rx_state == RX_RECV)) && !w_rx_overflow;
    w_rx_drop_done = w_in_hs && i_in_last && ((r_rx_state == RX_DROP) || w_rx_overflow);
    w_rx_pop       = w_data_rd && (r_rx_state == RX_FULL);
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_FILL: if (w_send_wr && (r_txfill != 8'd0)) w_tx_next = TX_SEND;
      TX_SEND: if (w_tx_hs && w_tx_last) w_tx_next = TX_FILL;
      default: w_tx_next = TX_FILL;
    endcase
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_EMPTY, RX_RECV: begin
        if (w_in_hs) begin
          if (w_rx_overflow) w_rx_next = i_in_last ? RX_EMPTY : RX_DROP;
          else               w_rx_next = i_in_last ? RX_FULL  : RX_RECV;
        end
      end
      RX_DROP: if (w_in_hs && i_in_last) w_rx_next = RX_EMPTY;
      RX_FULL: if (w_rx_pop && (r_rxrem == 8'd1)) w_rx_next = RX_EMPTY;
      default: w_rx_next = RX_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_FILL;
      r_rx_state <= RX_EMPTY;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txfill <= 8'd0;
      r_txrd   <= 8'd0;
      r_wcnt   <= 8'd0;
      r_rxrem  <= 8'd0;
      r_rdptr  <= 8'd0;
      r_ctrl   <= 2'b00;
      r_txerr  <= 1'b0;
      r_rxdrop <= 1'b0;
      r_txdone <= 1'b0;
    end else begin
      if (w_tx_push) r_txfill <= r_txfill + 8'd1;
      if (w_tx_hs) begin
        if (w_tx_last) begin
          r_txfill <= 8'd0;
          r_txrd   <= 8'd0;
        end else begin
          r_txrd <= r_txrd + 8'd1;
        end
      end
      if (w_rx_store) begin
        r_wcnt <= r_wcnt + 8'd1;
        if (i_in_last) begin
          r_rxrem <= r_wcnt + 8'd1;
          r_rdptr <= 8'd0;
        end
      end
      if (w_rx_pop) begin
        r_rxrem <= r_rxrem - 8'd1;
        r_rdptr <= r_rdptr + 8'd1;
      end
      if (w_rx_next == RX_EMPTY) r_wcnt <= 8'd0;
      if (w_ctrl_wr) r_ctrl <= i_wdata[1:0];
      // Clears come first so a coincident set wins.
      if (w_stat_wr && i_wdata[ST_TXERR])  r_txerr  <= 1'b0;
      if (w_stat_wr && i_wdata[ST_RXDROP]) r_rxdrop <= 1'b0;
      if (w_stat_wr && i_wdata[ST_TXDONE]) r_txdone <= 1'b0;
      if (w_tx_err)               r_txerr  <= 1'b1;
      if (w_rx_drop_done)         r_rxdrop <= 1'b1;
      if (w_tx_hs && w_tx_last)   r_txdone <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push)  r_txbuf[r_txfill[AW-1:0]] <= i_wdata[NOC_FLIT_WIDTH-1:0];
    if (w_rx_store) r_rxbuf[r_wcnt[AW-1:0]]   <= i_in_flit;
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_reg)
      REG_DATA: if (r_rx_state == RX_FULL) o_rdata = 32'(r_rxbuf[r_rdptr[AW-1:0]]);
      REG_STATUS: begin
        o_rdata[ST_RXAVAIL] = (r_rx_state == RX_FULL);
        o_rdata[ST_TXBUSY]  = (r_tx_state == TX_SEND);
        o_rdata[ST_TXERR]   = r_txerr;
        o_rdata[ST_RXDROP]  = r_rxdrop;
        o_rdata[ST_TXDONE]  = r_txdone;
        o_rdata[ST_RXREM_LSB +: 8]  = r_rxrem;
        o_rdata[ST_TXFILL_LSB +: 8] = r_txfill;
      end
      REG_CTRL: o_rdata[1:0] = r_ctrl;
      default:  o_rdata = 32'd0;
    endcase
  end

  assign o_out_valid = (r_tx_state == TX_SEND);
  assign o_out_flit  = o_out_valid ? r_txbuf[r_txrd[AW-1:0]] : '0;
  assign o_out_last  = o_out_valid && w_tx_last;
  assign o_in_ready  = !rst && (r_rx_state != RX_FULL);
  assign o_irq       = ((r_rx_state == RX_FULL) && r_ctrl[0]) || (r_txdone && r_ctrl[1]);

endmodule

// File: rtl/mpi_bb_mc.sv
// Top level: N channel instances, channel-index decode from the bus
// address, registered read-data mux and registered interrupt OR.
module mpi_bb_mc
  import mpi_bb_mc_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16,
  parameter int N              = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [N*NOC_FLIT_WIDTH-1:0] noc_out_flit,
  output logic [N-1:0]                noc_out_last,
  output logic [N-1:0]                noc_out_valid,
  input  logic [N-1:0]                noc_out_ready,
  input  logic [N*NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic [N-1:0]                noc_in_last,
  input  logic [N-1:0]                noc_in_valid,
  output logic [N-1:0]                noc_in_ready,
  input  logic [31:0]                 bb_addr_i,
  input  logic [31:0]                 bb_din_i,
  input  logic                        bb_en_i,
  input  logic                        bb_we_i,
  output logic [31:0]                 bb_dout_o,
  output logic                        irq
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] w_ch;
  logic [1:0]    w_reg;
  logic [31:0]   w_rdata [N];
  logic [N-1:0]  w_irq;
  logic [31:0]   w_rd_sel;
  logic [31:0]   r_dout;
  logic          r_irq;
  logic          w_unused_addr;

  assign w_ch          = bb_addr_i[4 +: CW];
  assign w_reg         = bb_addr_i[3:2];
  assign w_unused_addr = ^bb_addr_i;

  for (genvar c = 0; c < N; c++) begin : g_ch
    mpi_bb_mc_channel #(
      .NOC_FLIT_WIDTH(NOC_FLIT_WIDTH),
      .SIZE          (SIZE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (bb_en_i && bb_we_i && (w_ch == CW'(c))),
      .i_rd       (bb_en_i && !bb_we_i && (w_ch == CW'(c))),
      .i_reg      (w_reg),
      .i_wdata    (bb_din_i),
      .o_rdata    (w_rdata[c]),
      .o_out_flit (noc_out_flit[c*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH]),
      .o_out_last (noc_out_last[c]),
      .o_out_valid(noc_out_valid[c]),
      .i_out_ready(noc_out_ready[c]),
      .i_in_flit  (noc_in_flit[c*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH]),
      .i_in_last  (noc_in_last[c]),
      .i_in_valid (noc_in_valid[c]),
      .o_in_ready (noc_in_ready[c]),
      .o_irq      (w_irq[c])
    );
  end

  // Channel indices with no instance match nothing and read back as zero.
  always_comb begin
    w_rd_sel = 32'd0;
    for (int c = 0; c < N; c++) begin
      if (w_ch == CW'(c)) w_rd_sel = w_rdata[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= 32'd0;
      r_irq  <= 1'b0;
    end else begin
      r_irq <= |w_irq;
      if (bb_en_i && !bb_we_i) r_dout <= w_rd_sel;
    end
  end

  assign bb_dout_o = r_dout;
  assign irq       = r_irq;

endmodule
